zap_wb_store_drain: RTL and testbench
=====================================

Name: zap_wb_store_drain

Overview:
- Read-side consumer of a first-word-fall-through synchronous store FIFO (push by i_wr_en, pop by i_ack, head word on o_data, registered empty flag).
- Pops buffered store entries and issues them as Wishbone B3 classic single-write cycles.
- Keeps CYC asserted across back-to-back entries, up to MAX_BURST beats.
- Reports bus errors and a drain-complete flag for the cache/MMU flush sequencer.

Parameters:
- MAX_BURST, 32'd4, max consecutive beats under one CYC assertion. Range 1..16.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous reset, active-high.
- i_fifo_data  input  68  FIFO head entry: [67:36] address, [35:4] data, [3:0] byte select. Valid when i_fifo_empty_n=1.
- i_fifo_empty_n  input  1  FIFO not-empty, registered inside the FIFO.
- o_fifo_ack  output  1  pop strobe to the FIFO.
- o_wb_cyc  output  1  Wishbone CYC.
- o_wb_stb  output  1  Wishbone STB.
- o_wb_we  output  1  Wishbone WE, always 1 while STB is high.
- o_wb_adr  output  32  Wishbone address.
- o_wb_dat  output  32  Wishbone write data.
- o_wb_sel  output  4  Wishbone byte select.
- o_wb_cti  output  3  cycle type, constant 3'b000.
- o_wb_bte  output  2  burst type, constant 2'b00.
- i_wb_ack  input  1  Wishbone ACK.
- i_wb_err  input  1  Wishbone ERR.
- o_err  output  1  sticky bus-error flag.
- o_err_adr  output  32  address of the first errored write.
- o_idle  output  1  FIFO empty and no write in flight.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous, active-high.
- Reset state: FSM=IDLE; o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel=0; o_err=0; o_err_adr=0; beat_cnt=0.
- Reset forces o_fifo_ack=0 combinationally.
- All Wishbone outputs are registered. o_fifo_ack and o_idle are combinational.
- IDLE:
  - cyc=stb=0.
  - If i_fifo_empty_n: o_fifo_ack=1 this cycle; capture address/data/sel from i_fifo_data into the output registers; beat_cnt<=0; next state STB.
- STB:
  - cyc=stb=we=1; adr/dat/sel held stable until the beat terminates.
  - Beat terminates on i_wb_ack or i_wb_err. If both are high together, treat as error.
  - On error: if o_err=0, latch o_err_adr<=o_wb_adr. Set o_err<=1. Then go to IDLE (cyc, stb low next cycle).
  - On ack, continue in STB only if i_fifo_empty_n=1 and beat_cnt<MAX_BURST-1. Then: o_fifo_ack=1, capture the new head, beat_cnt++, stb stays high.
  - On ack with either condition failing: next state IDLE, cyc and stb deasserted.
- Minimum one-cycle CYC-low gap between transactions. IDLE always spends one cycle with cyc=0 before reasserting.
- FIFO timing: head data is valid the cycle after a pop. An entry is always captured at least one cycle before its ack arrives, so the next head is valid at the ack cycle.
- o_fifo_ack is asserted only when i_fifo_empty_n=1 and i_reset=0. At most one pop per cycle, exactly one pop per entry.
- i_wb_ack and i_wb_err are ignored outside STB.
- o_idle = (state==IDLE) & !i_fifo_empty_n.
- o_err is cleared only by reset. Entries are still drained after an error; the errored entry is dropped, not retried.
- Reset mid-transfer: cyc drops at the next edge. The in-flight entry is lost; it was already popped.

Test Plan:
- Single write, 2 wait states. Load one entry adr=0x0000_1000, dat=0xDEAD_BEEF, sel=4'hF.
  -> o_fifo_ack pulses 1 cycle (T0); cyc/stb high T1..T3 with those values; ack at T3; cyc=0 at T4; o_idle=1.
- Six entries, addresses 0x100..0x114, MAX_BURST=4, zero-wait ACK.
  -> 4 beats under one continuous cyc; 1 cycle cyc=0; 2 beats; 6 pops total; data order preserved.
- Three entries, ERR on beat 2 (adr 0x204).
  -> o_err=1, o_err_adr=0x204; cyc drops after beat 2; entry 3 written in a new cycle after the gap; o_err stays 1.
- ACK and ERR asserted together on a beat.
  -> treated as error, o_err_adr captured, FSM returns to IDLE.
- Reset asserted while in STB with ACK withheld.
  -> next cycle cyc=stb=0, o_err=0, o_fifo_ack=0 during reset; normal drain resumes after release.
- FIFO empties after beat 1, refills 3 cycles later.
  -> cyc drops after beat 1; new transaction starts one cycle after refill, beginning with a pop in IDLE.

Source files
------------

// File: rtl/zap_wb_store_drain.sv
// Purpose: drains a FWFT store FIFO onto Wishbone B3 classic single writes, up to MAX_BURST beats per CYC.
// Latency: one cycle from FIFO not-empty (pop in IDLE) to CYC/STB; next beat issued the cycle after ACK.
// Backpressure: a beat holds STB until ACK/ERR; the FIFO is popped only when an entry can be issued next.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_fifo_data/_empty_n    FIFO head {adr[67:36], dat[35:4], sel[3:0]} and registered not-empty
//   o_fifo_ack              combinational pop strobe
//   o_wb_*                  registered Wishbone master outputs (cti/bte constant classic)
//   i_wb_ack, i_wb_err      beat termination; ERR wins when both are high
//   o_err, o_err_adr        sticky bus-error flag and address of the first errored write
//   o_idle                  FSM idle and FIFO empty
module zap_wb_store_drain #(
  parameter logic [31:0] MAX_BURST = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [67:0] i_fifo_data,
  input  logic        i_fifo_empty_n,
  output logic        o_fifo_ack,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  output logic [1:0]  o_wb_bte,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_err,
  output logic [31:0] o_err_adr,
  output logic        o_idle
);

  typedef enum logic {S_IDLE, S_STB} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] beat_cnt;
  logic       beat_ok;   // clean ACK (ERR takes priority over a simultaneous ACK)
  logic       more;      // another entry may follow under the same CYC

  assign beat_ok  = i_wb_ack & ~i_wb_err;
  assign more     = i_fifo_empty_n & ({28'd0, beat_cnt} < (MAX_BURST - 32'd1));
  assign o_wb_cti = 3'b000;
  assign o_wb_bte = 2'b00;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_fifo_empty_n) state_nxt = S_STB;
      S_STB: begin
        if (i_wb_err)               state_nxt = S_IDLE;
        else if (i_wb_ack && !more) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs. A pop always coincides with loading the next beat,
  // so the FIFO head presented afterwards is only consumed on a later cycle.
  always_comb begin
    o_fifo_ack = 1'b0;
    if (!i_reset) begin
      case (state)
        S_IDLE:  o_fifo_ack = i_fifo_empty_n;
        S_STB:   o_fifo_ack = beat_ok & more;
        default: o_fifo_ack = 1'b0;
      endcase
    end
    o_idle = (state == S_IDLE) & ~i_fifo_empty_n;
  end

  // Registered Wishbone outputs, beat counter and error capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_adr  <= 32'd0;
      o_wb_dat  <= 32'd0;
      o_wb_sel  <= 4'd0;
      o_err     <= 1'b0;
      o_err_adr <= 32'd0;
      beat_cnt  <= 4'd0;
    end else begin
      // CYC/STB/WE simply mirror the state we are about to enter, which also
      // guarantees one CYC-low cycle whenever the FSM passes through IDLE.
      o_wb_cyc <= (state_nxt == S_STB);
      o_wb_stb <= (state_nxt == S_STB);
      o_wb_we  <= (state_nxt == S_STB);

      if (o_fifo_ack) begin
        o_wb_adr <= i_fifo_data[67:36];
        o_wb_dat <= i_fifo_data[35:4];
        o_wb_sel <= i_fifo_data[3:0];
        beat_cnt <= (state == S_IDLE) ? 4'd0 : beat_cnt + 4'd1;
      end

      // Errored entry is dropped; only the first error address is kept.
      if (state == S_STB && i_wb_err) begin
        if (!o_err) o_err_adr <= o_wb_adr;
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zap_wb_store_drain.sv
// Purpose: self-checking bench for zap_wb_store_drain with a queue-based FIFO and a Wishbone slave model.
// Latency: n/a (bench).
// Backpressure: the slave model inserts fixed or random wait states and can withhold ACK entirely.
module tb_zap_wb_store_drain;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [67:0] fifo_data = '0;
  logic        fifo_empty_n = 1'b0;
  logic        fifo_ack;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        err;
  logic [31:0] err_adr;
  logic        idle;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zap_wb_store_drain #(.MAX_BURST(32'(MB))) dut (
    .i_clk(clk), .i_reset(rst),
    .i_fifo_data(fifo_data), .i_fifo_empty_n(fifo_empty_n), .o_fifo_ack(fifo_ack),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_adr(adr), .o_wb_dat(dat),
    .o_wb_sel(sel), .o_wb_cti(cti), .o_wb_bte(bte), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_err(err), .o_err_adr(err_adr), .o_idle(idle)
  );

  // ---------------- FIFO model: FWFT, registered flags ----------------
  logic [67:0] fq[$];
  bit          hold = 1'b1;   // masks not-empty while a batch is being loaded
  int          pops = 0;
  int          bad_pop = 0;

  always @(posedge clk) begin
    if (fifo_ack) begin
      if (!fifo_empty_n || fq.size() == 0) bad_pop++;
      else void'(fq.pop_front());
      pops++;
    end
    fifo_empty_n <= (fq.size() != 0) && !hold;
    fifo_data    <= (fq.size() != 0) ? fq[0] : 68'd0;
  end

  // ---------------- Wishbone slave model + recorder ----------------
  int          wait_fix = 0;  // <0: random 0..2 wait states per beat
  bit          stall = 1'b0;
  bit [63:0]   err_mask = '0;
  bit [63:0]   both_mask = '0;
  int          beat_idx = 0, txn = 0, wcnt = 0, cur_wait = 0;
  int          proto_err = 0, unstable = 0;
  bit          prev_cyc = 1'b0;
  logic [31:0] h_adr, h_dat;
  logic [3:0]  h_sel;
  logic [31:0] b_adr[$], b_dat[$];
  logic [3:0]  b_sel[$];
  int          b_txn[$];

  always begin
    @(posedge clk);
    #1;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (cyc && !prev_cyc) txn++;
    prev_cyc = cyc;
    if (stb !== cyc || (stb && we !== 1'b1) || cti !== 3'b000 || bte !== 2'b00) proto_err++;
    if (stb && !stall) begin
      if (wcnt == 0) begin
        h_adr = adr; h_dat = dat; h_sel = sel;
        cur_wait = (wait_fix >= 0) ? wait_fix : int'($urandom_range(2, 0));
      end else if (adr !== h_adr || dat !== h_dat || sel !== h_sel) unstable++;
      if (wcnt >= cur_wait) begin
        wb_err = err_mask[beat_idx] | both_mask[beat_idx];
        wb_ack = !err_mask[beat_idx];
        b_adr.push_back(adr); b_dat.push_back(dat); b_sel.push_back(sel); b_txn.push_back(txn);
        beat_idx++;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  // ---------------- Reference model ----------------
  // Entries leave in FIFO order; a CYC run ends after MAX_BURST beats or an errored beat
  // (the FIFO is kept full in these scenarios, so emptiness never splits a run).
  int exp_txn[64];
  function automatic void build_exp(input int n);
    int g = 0, c = 0;
    for (int i = 0; i < n; i++) begin
      exp_txn[i] = g;
      c++;
      if (err_mask[i] || both_mask[i] || c == MB) begin g++; c = 0; end
    end
  endfunction

  function automatic logic [67:0] ent(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    return {a, d, s};
  endfunction

  // ---------------- Stimulus helpers ----------------
  task automatic clear_rec();
    b_adr.delete(); b_dat.delete(); b_sel.delete(); b_txn.delete();
    beat_idx = 0; err_mask = '0; both_mask = '0; pops = 0; bad_pop = 0;
    proto_err = 0; unstable = 0; wait_fix = 0; stall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    hold = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fq.size() == 0 && !fifo_empty_n && idle && !cyc) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    bit ok;
    clear_rec();
    rst = 1'b1; hold = 1'b0;
    @(negedge clk); fq.push_back(ent(32'hA5A5_0000, 32'h1234_5678, 4'h3));
    repeat (2) @(negedge clk);
    n_cmp++; if ({cyc, stb, we} !== 3'b000) begin n_bad++; $display("FAIL reset_cyc_stb_we: got %b want 000", {cyc, stb, we}); end
    n_cmp++; if ({adr, dat, sel} !== 68'd0) begin n_bad++; $display("FAIL reset_adr_dat_sel: got %h want 0", {adr, dat, sel}); end
    n_cmp++; if ({err, err_adr} !== 33'd0) begin n_bad++; $display("FAIL reset_err: got %b/%h want 0/0", err, err_adr); end
    n_cmp++; if (fifo_ack !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_ack: got %b want 0 (fifo not empty)", fifo_ack); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL reset_idle_nonempty: got %b want 0", idle); end
    rst = 1'b0;
    drain(50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_drain_timeout: got timeout want drained"); end
    n_cmp++; if (b_adr.size() !== 1 || pops !== 1) begin n_bad++; $display("FAIL reset_post_drain: got beats=%0d pops=%0d want 1/1", b_adr.size(), pops); end
  endtask

  task automatic test_single();
    clear_rec();
    wait_fix = 2;
    @(negedge clk); fq.push_back(ent(32'h0000_1000, 32'hDEAD_BEEF, 4'hF)); hold = 1'b0;
    @(negedge clk);  // T0
    n_cmp++; if ({fifo_ack, cyc} !== 2'b10) begin n_bad++; $display("FAIL single_T0: got ack/cyc=%b want 10", {fifo_ack, cyc}); end
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({cyc, stb, we} !== 3'b111 || adr !== 32'h0000_1000 || dat !== 32'hDEAD_BEEF || sel !== 4'hF || fifo_ack !== 1'b0) begin
        n_bad++; $display("FAIL single_T%0d: got cyc/stb/we=%b adr=%h dat=%h sel=%h ack=%b want 111 1000 deadbeef f 0",
                          t, {cyc, stb, we}, adr, dat, sel, fifo_ack);
      end
    end
    @(negedge clk);  // T4
    n_cmp++; if ({cyc, stb, idle} !== 3'b001) begin n_bad++; $display("FAIL single_T4: got cyc/stb/idle=%b want 001", {cyc, stb, idle}); end
    n_cmp++; if (pops !== 1 || b_adr.size() !== 1 || bad_pop !== 0) begin n_bad++; $display("FAIL single_pops: got pops=%0d beats=%0d bad=%0d want 1/1/0", pops, b_adr.size(), bad_pop); end
  endtask

  // Shared body of the batch scenarios: load n entries with hold, drain, compare against the model.
  task automatic test_batch(input string nm, input logic [31:0] base, input bit rnd_adr, input int n,
                            input bit exp_err, input logic [31:0] exp_err_adr);
    logic [67:0] e[$];
    bit ok;
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e.push_back(ent(rnd_adr ? ($urandom() & 32'hFFFF_FFFC) : base + 32'(4 * i), $urandom(), 4'($urandom_range(15, 1))));
      fq.push_back(e[i]);
    end
    build_exp(n);
    drain(40 * n + 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_drain_timeout: got timeout want drained", nm); end
    n_cmp++; if (b_adr.size() !== n || pops !== n) begin n_bad++; $display("FAIL %s_count: got beats=%0d pops=%0d want %0d", nm, b_adr.size(), pops, n); end
    for (int i = 0; i < n && i < b_adr.size(); i++) begin
      n_cmp++;
      if ({b_adr[i], b_dat[i], b_sel[i]} !== e[i] || (b_txn[i] - b_txn[0]) !== exp_txn[i]) begin
        n_bad++; $display("FAIL %s_beat%0d: got %h txn%0d want %h txn%0d", nm, i, {b_adr[i], b_dat[i], b_sel[i]},
                          b_txn[i] - b_txn[0], e[i], exp_txn[i]);
      end
    end
    n_cmp++; if (err !== exp_err || err_adr !== exp_err_adr) begin n_bad++; $display("FAIL %s_err: got %b/%h want %b/%h", nm, err, err_adr, exp_err, exp_err_adr); end
    n_cmp++; if (bad_pop !== 0 || proto_err !== 0 || unstable !== 0) begin n_bad++; $display("FAIL %s_protocol: got badpop=%0d proto=%0d unstable=%0d want 0", nm, bad_pop, proto_err, unstable); end
  endtask

  task automatic test_burst6();
    do_reset(); clear_rec();
    test_batch("burst6", 32'h100, 1'b0, 6, 1'b0, 32'd0);
  endtask

  task automatic test_err();
    do_reset(); clear_rec();
    err_mask[1] = 1'b1;
    test_batch("err", 32'h200, 1'b0, 3, 1'b1, 32'h204);
  endtask

  task automatic test_ack_err_both();
    do_reset(); clear_rec();
    both_mask[2] = 1'b1;
    err_mask[3]  = 1'b1;  // a later error must not overwrite the first address
    test_batch("both", 32'h300, 1'b0, 5, 1'b1, 32'h308);
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_rec();   // o_err is still set from the previous scenario
    stall = 1'b1;
    @(negedge clk);
    fq.push_back(ent(32'h400, 32'h1111_1111, 4'h1));
    fq.push_back(ent(32'h404, 32'h2222_2222, 4'h2));
    hold = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = stb; end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmid_stb_timeout: got no stb want stb"); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({cyc, stb, err} !== 3'b000 || err_adr !== 32'd0) begin n_bad++; $display("FAIL rmid_after_reset: got cyc/stb/err=%b adr=%h want 000 0", {cyc, stb, err}, err_adr); end
    n_cmp++; if (fifo_ack !== 1'b0 || fifo_empty_n !== 1'b1) begin n_bad++; $display("FAIL rmid_ack_gated: got ack=%b empty_n=%b want 0/1", fifo_ack, fifo_empty_n); end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    drain(50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_drain_timeout: got timeout want drained"); end
    n_cmp++; if (b_adr.size() !== 1 || pops !== 2 || (b_adr.size() > 0 && b_adr[0] !== 32'h404)) begin
      n_bad++; $display("FAIL rmid_resume: got beats=%0d pops=%0d want 1 beat at 404, pops 2", b_adr.size(), pops);
    end
  endtask

  task automatic test_refill();
    bit ok, up, down;
    do_reset(); clear_rec();
    @(negedge clk); fq.push_back(ent(32'h500, 32'hA0, 4'hF)); hold = 1'b0;
    up = 1'b0; down = 1'b0;
    for (int k = 0; k < 30 && !down; k++) begin
      @(negedge clk);
      if (cyc) up = 1'b1; else if (up) down = 1'b1;
    end
    n_cmp++; if (!down) begin n_bad++; $display("FAIL refill_first_timeout: got no cyc drop want drop"); end
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 3; i++) fq.push_back(ent(32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF));
    @(negedge clk);
    n_cmp++; if ({fifo_ack, cyc} !== 2'b10) begin n_bad++; $display("FAIL refill_pop_in_idle: got ack/cyc=%b want 10", {fifo_ack, cyc}); end
    @(negedge clk);
    n_cmp++; if (cyc !== 1'b1 || adr !== 32'h504) begin n_bad++; $display("FAIL refill_restart: got cyc=%b adr=%h want 1 504", cyc, adr); end
    drain(60, ok);
    n_cmp++; if (!ok || b_txn.size() !== 4) begin n_bad++; $display("FAIL refill_drain: got ok=%b beats=%0d want 1/4", ok, b_txn.size()); end
    else begin
      n_cmp++;
      if (b_txn[1] - b_txn[0] !== 1 || b_txn[3] - b_txn[1] !== 0 || pops !== 4) begin
        n_bad++; $display("FAIL refill_grouping: got txn %0d %0d %0d %0d pops=%0d want 0 1 1 1 pops 4",
                          0, b_txn[1] - b_txn[0], b_txn[2] - b_txn[0], b_txn[3] - b_txn[0], pops);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      bit          e_err;
      logic [31:0] e_adr;
      do_reset(); clear_rec();
      wait_fix = -1;
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) begin
        err_mask[i]  = ($urandom_range(4, 0) == 0);
        both_mask[i] = !err_mask[i] && ($urandom_range(7, 0) == 0);
      end
      // The expected error address depends on generated addresses, so compute it afterwards.
      test_batch_rand(n, e_err, e_adr);
    end
  endtask

  task automatic test_batch_rand(input int n, output bit e_err, output logic [31:0] e_adr);
    logic [67:0] e[$];
    bit ok;
    e_err = 1'b0; e_adr = 32'd0;
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e.push_back(ent($urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(15, 1))));
      fq.push_back(e[i]);
      if ((err_mask[i] || both_mask[i]) && !e_err) begin e_err = 1'b1; e_adr = e[i][67:36]; end
    end
    build_exp(n);
    drain(40 * n + 20, ok);
    n_cmp++; if (!ok || b_adr.size() !== n || pops !== n) begin n_bad++; $display("FAIL rand_count: got ok=%b beats=%0d pops=%0d want 1/%0d", ok, b_adr.size(), pops, n); end
    for (int i = 0; i < n && i < b_adr.size(); i++) begin
      n_cmp++;
      if ({b_adr[i], b_dat[i], b_sel[i]} !== e[i] || (b_txn[i] - b_txn[0]) !== exp_txn[i]) begin
        n_bad++; $display("FAIL rand_beat%0d: got %h txn%0d want %h txn%0d", i, {b_adr[i], b_dat[i], b_sel[i]},
                          b_txn[i] - b_txn[0], e[i], exp_txn[i]);
      end
    end
    n_cmp++; if (err !== e_err || err_adr !== e_adr) begin n_bad++; $display("FAIL rand_err: got %b/%h want %b/%h", err, err_adr, e_err, e_adr); end
    n_cmp++; if (bad_pop !== 0 || proto_err !== 0 || unstable !== 0) begin n_bad++; $display("FAIL rand_protocol: got badpop=%0d proto=%0d unstable=%0d want 0", bad_pop, proto_err, unstable); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst6();
    test_err();
    test_ack_err_both();
    test_reset_mid();
    test_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
